text_vram_scheduler: RTL and testbench

Sequences the 80x30 text-mode display pipeline and shares the single-port text VRAM between the display scan and the CPU. It generates the pixel raster position ({y,x}) and prefetches each cell's character code just in time. The outputs feed gpu_controller's address/data_in pair. CPU read/write requests are granted in any cycle the display does not need the VRAM port.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/raster_counter.sv | 47 ++++
 rtl/text_vram_scheduler.sv | 114 +++++++++++
 tb/tb_text_vram_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared text-mode timing constants and the CPU access FSM state type.
//   Holds the default 640x480 (800x525 total) timing, the 8x16 cell geometry,
//   the 80x30 character grid size and the number of text cells.
package gpu_pkg;

   localparam int H_VISIBLE           = 640;
   localparam int H_TOTAL             = 800;
   localparam int V_VISIBLE           = 480;
   localparam int V_TOTAL             = 525;
   localparam int CHAR_WIDTH          = 8;
   localparam int CHAR_HEIGHT         = 16;
   localparam int DISPLAY_CHAR_WIDTH  = 80;
   localparam int DISPLAY_CHAR_HEIGHT = 30;
   localparam int TEXT_CELLS          = DISPLAY_CHAR_WIDTH * DISPLAY_CHAR_HEIGHT;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} cpu_state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: pixel raster position plus a two-pixel lookahead used to schedule cell fetches.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   x_o, y_o     : current raster position
//   fx_o, fy_o   : position two pixel clocks ahead, with line and frame wrap
//   pix_valid_o  : current position lies inside the visible area
module raster_counter #(
   parameter int H_VISIBLE = gpu_pkg::H_VISIBLE,
   parameter int H_TOTAL   = gpu_pkg::H_TOTAL,
   parameter int V_VISIBLE = gpu_pkg::V_VISIBLE,
   parameter int V_TOTAL   = gpu_pkg::V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic [9:0] fx_o,
   output logic [9:0] fy_o,
   output logic       pix_valid_o
);

   logic [9:0] x_q, x_d, y_q, y_d;
   logic       x_last, y_last, ahead_wrap;

   always_comb begin
      x_last      = x_q == 10'(H_TOTAL - 1);
      y_last      = y_q == 10'(V_TOTAL - 1);
      x_d         = x_last ? '0 : x_q + 10'd1;
      y_d         = !x_last ? y_q : y_last ? '0 : y_q + 10'd1;
      // the lookahead crosses into the next line for the last two pixels of a line
      ahead_wrap  = x_q >= 10'(H_TOTAL - 2);
      fx_o        = ahead_wrap ? x_q - 10'(H_TOTAL - 2) : x_q + 10'd2;
      fy_o        = !ahead_wrap ? y_q : y_last ? '0 : y_q + 10'd1;
      x_o         = x_q;
      y_o         = y_q;
      pix_valid_o = (x_q < 10'(H_VISIBLE)) && (y_q < 10'(V_VISIBLE));
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end

endmodule

// File: rtl/text_vram_scheduler.sv
// text_vram_scheduler: text-mode raster sequencer sharing a single-port VRAM between display prefetch and CPU.
//   clk, rst                       : pixel clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          : CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata             : one-cycle completion pulse, read data (held)
//   mem_en/we/addr/wdata, mem_rdata: VRAM port, synchronous read (data one cycle after mem_en)
//   pix_address, pix_char, pix_valid: raster {y,x}, character code of that cell, visible flag
module text_vram_scheduler #(
   parameter int H_VISIBLE           = gpu_pkg::H_VISIBLE,
   parameter int H_TOTAL             = gpu_pkg::H_TOTAL,
   parameter int V_VISIBLE           = gpu_pkg::V_VISIBLE,
   parameter int V_TOTAL             = gpu_pkg::V_TOTAL,
   parameter int CHAR_WIDTH          = gpu_pkg::CHAR_WIDTH,
   parameter int CHAR_HEIGHT         = gpu_pkg::CHAR_HEIGHT,
   parameter int DISPLAY_CHAR_WIDTH  = gpu_pkg::DISPLAY_CHAR_WIDTH,
   parameter int DISPLAY_CHAR_HEIGHT = gpu_pkg::DISPLAY_CHAR_HEIGHT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [11:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [19:0] pix_address,
   output logic [7:0]  pix_char,
   output logic        pix_valid
);

   import gpu_pkg::*;

   localparam int CW_LG = $clog2(CHAR_WIDTH);
   localparam int CH_LG = $clog2(CHAR_HEIGHT);
   localparam int CELLS = DISPLAY_CHAR_WIDTH * DISPLAY_CHAR_HEIGHT;

   logic [9:0]  x, y, fx, fy;
   logic [11:0] disp_addr;
   logic        disp_fetch, cpu_issue, cpu_hit;
   logic        fetch_q, rd_q, oob_q;
   logic [7:0]  pix_char_q, pix_char_d, cpu_rdata_q, cpu_rdata_d;
   cpu_state_t  state_q, state_d;

   raster_counter #(
      .H_VISIBLE(H_VISIBLE),
      .H_TOTAL  (H_TOTAL),
      .V_VISIBLE(V_VISIBLE),
      .V_TOTAL  (V_TOTAL)
   ) u_raster (
      .clk        (clk),
      .rst        (rst),
      .x_o        (x),
      .y_o        (y),
      .fx_o       (fx),
      .fy_o       (fy),
      .pix_valid_o(pix_valid)
   );

   // Fetching two pixels early lets the read data land in pix_char exactly at the cell's first pixel.
   always_comb begin
      disp_fetch = ((fx & 10'(CHAR_WIDTH - 1)) == '0) && (fx < 10'(H_VISIBLE)) && (fy < 10'(V_VISIBLE));
      disp_addr  = 12'(fy >> CH_LG) * 12'(DISPLAY_CHAR_WIDTH) + 12'(fx >> CW_LG);
      cpu_hit    = cpu_addr < 12'(CELLS);
      // rst gating keeps the port quiet while a request is held through reset
      cpu_issue  = (state_q == IDLE) && cpu_req && !disp_fetch && !rst;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;

   always_comb
      state_d = (state_q == IDLE) ? (cpu_issue ? WAIT : IDLE) : (state_q == WAIT) ? ACK : IDLE;

   always_comb begin
      cpu_ack   = state_q == ACK;
      mem_en    = disp_fetch || (cpu_issue && cpu_hit);
      mem_we    = cpu_issue && cpu_hit && cpu_we;
      mem_addr  = disp_fetch ? disp_addr : (cpu_issue && cpu_hit) ? cpu_addr : '0;
      mem_wdata = mem_we ? cpu_wdata : '0;
   end

   // Display and CPU read data never arrive in the same cycle: a CPU issue excludes a fetch in that cycle.
   always_comb begin
      pix_char_d  = fetch_q ? mem_rdata : pix_char_q;
      cpu_rdata_d = (state_q == WAIT && rd_q) ? (oob_q ? '0 : mem_rdata) : cpu_rdata_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fetch_q     <= 1'b0;
         rd_q        <= 1'b0;
         oob_q       <= 1'b0;
         pix_char_q  <= '0;
         cpu_rdata_q <= '0;
      end else begin
         fetch_q     <= disp_fetch;
         pix_char_q  <= pix_char_d;
         cpu_rdata_q <= cpu_rdata_d;
         if (cpu_issue) begin
            rd_q  <= !cpu_we;
            oob_q <= !cpu_hit;
         end
      end

   assign pix_address = {y, x};
   assign pix_char    = pix_char_q;
   assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_text_vram_scheduler.sv
// tb_text_vram_scheduler: directed checks of raster, display prefetch, CPU arbitration and reset abort.
module tb_text_vram_scheduler;

   // Shortened frame (35 lines, 2 cell rows) keeps a full frame wrap within a small cycle budget.
   localparam int HT = 800;
   localparam int VT = 35;

   logic        clk = 1'b0, rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack, mem_en, mem_we, pix_valid;
   logic [7:0]  cpu_rdata, mem_wdata, pix_char;
   logic [7:0]  mem_rdata = '0;
   logic [11:0] mem_addr;
   logic [19:0] pix_address;
   logic [7:0]  vram [4096];
   int          mx = 0, my = 0, total = 0, bad = 0;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [7:0]  wdata;
      int          sx;
      int          sy;
      int          stall;
      logic        en;
      logic [11:0] daddr;
      logic [7:0]  rdata;
   } vec_t;
   vec_t v [8];

   always #5 clk = ~clk;

   text_vram_scheduler #(
      .V_VISIBLE(32),
      .V_TOTAL(VT),
      .DISPLAY_CHAR_HEIGHT(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pix_address(pix_address), .pix_char(pix_char), .pix_valid(pix_valid)
   );

   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) vram[mem_addr] = mem_wdata;
         else        mem_rdata <= vram[mem_addr];
      end

   always @(posedge clk or posedge rst)
      if (rst) begin
         mx <= 0;
         my <= 0;
      end else if (mx == HT - 1) begin
         mx <= 0;
         my <= (my == VT - 1) ? 0 : my + 1;
      end else mx <= mx + 1;

   always @(negedge clk)
      if (mem_we && !mem_en) begin
         bad++;
         $display("FAIL we_without_en got mem_we=1 mem_en=0 exp mem_en=1 at x=%0d y=%0d", mx, my);
      end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at x=%0d y=%0d", nm, got, exp, mx, my);
      end
   endtask

   task automatic wait_pos(input int x, input int y);
      bit hit = 0;
      for (int i = 0; i < 30000 && !hit; i++) begin
         @(negedge clk);
         hit = (mx == x && my == y);
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL reach_pos got x=%0d y=%0d exp x=%0d y=%0d", mx, my, x, y);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) vram[i] = 8'(i * 7 + 3);
      vram[0]  = 8'h41;
      vram[1]  = 8'h42;
      vram[80] = 8'h50;
      v[0] = '{1'b1, 12'd5,    8'h5A, 1,   1, 0, 1'b1, 12'd0, 8'h00};
      v[1] = '{1'b0, 12'd5,    8'h00, 6,   2, 1, 1'b1, 12'd1, 8'h5A};
      v[2] = '{1'b0, 12'd10,   8'h00, 22,  3, 1, 1'b1, 12'd3, 8'h49};
      v[3] = '{1'b1, 12'd2400, 8'h77, 33,  4, 0, 1'b0, 12'd0, 8'h49};
      v[4] = '{1'b0, 12'd4095, 8'h00, 41,  5, 0, 1'b0, 12'd0, 8'h00};
      v[5] = '{1'b0, 12'd79,   8'h00, 700, 6, 0, 1'b1, 12'd0, 8'h2C};
      v[6] = '{1'b1, 12'd159,  8'h33, 638, 7, 0, 1'b1, 12'd0, 8'h2C};
      v[7] = '{1'b0, 12'd159,  8'h00, 798, 8, 1, 1'b1, 12'd0, 8'h33};

      #2 rst = 1'b1;
      cpu_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_pix_char", pix_char, 0);
      chk("rst_pix_address", pix_address, 0);
      cpu_req = 1'b0;
      rst = 1'b0;
      #1;
      chk("first_cell_char", pix_char, 8'h00);
      chk("first_cell_valid", pix_valid, 1);

      wait_pos(6, 0);
      chk("cell1_fetch_en", mem_en, 1);
      chk("cell1_fetch_addr", mem_addr, 1);
      chk("cell0_char_x6", pix_char, 8'h00);
      wait_pos(8, 0);
      chk("cell1_char", pix_char, vram[1]);

      for (int i = 0; i < 8; i++) begin
         int n;
         bit acked;
         wait_pos(v[i].sx, v[i].sy);
         cpu_req = 1'b1;
         cpu_we = v[i].we;
         cpu_addr = v[i].addr;
         cpu_wdata = v[i].wdata;
         #1;
         if (v[i].stall != 0) begin
            chk("stall_disp_en", mem_en, 1);
            chk("stall_disp_we", mem_we, 0);
            chk("stall_disp_addr", mem_addr, v[i].daddr);
            @(negedge clk);
            #1;
         end
         chk("issue_en", mem_en, v[i].en);
         chk("issue_we", mem_we, v[i].en & v[i].we);
         if (v[i].en) chk("issue_addr", mem_addr, v[i].addr);
         if (v[i].en && v[i].we) chk("issue_wdata", mem_wdata, v[i].wdata);
         n = v[i].stall;
         acked = 0;
         for (int k = 0; k < 8 && !acked; k++) begin
            @(negedge clk);
            n++;
            acked = cpu_ack;
         end
         chk("ack_latency", n, v[i].stall + 2);
         chk("cpu_rdata", cpu_rdata, v[i].rdata);
         cpu_req = 1'b0;
         @(negedge clk);
         chk("ack_one_cycle", cpu_ack, 0);
      end
      chk("vram_write5", vram[5], 8'h5A);
      chk("vram_write159", vram[159], 8'h33);
      chk("vram_oob_untouched", vram[2400], 8'hA3);

      wait_pos(640, 15);
      chk("hblank_invalid", pix_valid, 0);
      wait_pos(798, 15);
      chk("row1_fetch_en", mem_en, 1);
      chk("row1_fetch_we", mem_we, 0);
      chk("row1_fetch_addr", mem_addr, 80);
      chk("raster_pos", pix_address, {10'd15, 10'd798});
      wait_pos(0, 16);
      chk("row1_char_x0", pix_char, 8'h50);
      wait_pos(7, 16);
      chk("row1_char_x7", pix_char, 8'h50);
      wait_pos(700, 16);
      chk("hold_in_blank", pix_char, 8'h33);

      wait_pos(798, VT - 1);
      chk("frame_fetch_en", mem_en, 1);
      chk("frame_fetch_addr", mem_addr, 0);
      chk("vblank_invalid", pix_valid, 0);
      wait_pos(799, VT - 1);
      chk("raster_last", pix_address, {10'd34, 10'd799});
      wait_pos(0, 0);
      chk("frame_wrap_pos", pix_address, 0);
      chk("frame2_char_x0", pix_char, 8'h41);
      wait_pos(6, 0);
      chk("frame2_fetch1", mem_addr, 1);
      chk("frame2_char_x6", pix_char, 8'h41);
      wait_pos(8, 0);
      chk("frame2_char_x8", pix_char, 8'h42);

      wait_pos(100, 1);
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 12'd5;
      @(negedge clk);
      chk("pre_abort_ack", cpu_ack, 0);
      rst = 1'b1;
      #1;
      chk("abort_mem_en", mem_en, 0);
      chk("abort_mem_addr", mem_addr, 0);
      chk("abort_rdata", cpu_rdata, 0);
      chk("abort_pix_char", pix_char, 0);
      chk("abort_pix_address", pix_address, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_ack", cpu_ack, 0);
      end
      cpu_req = 1'b0;
      rst = 1'b0;
      #1;
      chk("restart_pos0", pix_address, 0);
      @(negedge clk);
      chk("restart_pos1", pix_address, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("restart_no_ack", cpu_ack, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
